// File: rtl/cpu_core_mc.sv
// cpu_core_mc: multi-cycle 8-bit-class CPU core.
// It fetches instructions over a req/valid handshake (FETCH) and then executes them (EXEC).
// It has a HALT instruction, a retire strobe and a combinational debug read port.
// Instruction format: {op[3:0], a[RA-1:0], b[RA-1:0]}. Results are written to R[a].
module cpu_core_mc #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    parameter int PC_W   = 4,
    localparam int RA    = $clog2(NREG),
    localparam int IW    = 4 + 2 * RA
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_valid,
    input  logic [IW-1:0]     imem_data,
    output logic [PC_W-1:0]   pc,
    output logic              retire,
    output logic              halted,
    output logic              flag_z,
    output logic              flag_c,
    input  logic [RA-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_MOVI = 4'h7;
    localparam logic [3:0] OP_CMP  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JNZ  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hC;

    state_t              state_q;
    logic                imem_req_q;
    logic                retire_q;
    logic                halted_q;
    logic [IW-1:0]       ir_q;
    logic [PC_W-1:0]     pc_q;
    logic                z_q;
    logic                c_q;
    logic [DATA_W-1:0]   regs_q [NREG];

    logic [3:0]          op_s;
    logic [RA-1:0]       a_s;
    logic [RA-1:0]       b_s;
    logic [DATA_W-1:0]   ra_s;
    logic [DATA_W-1:0]   rb_s;
    logic [DATA_W:0]     sum_s;
    logic [DATA_W:0]     diff_s;
    logic [DATA_W-1:0]   res_d;
    logic                wr_en_s;
    logic                upd_z_s;
    logic                upd_c_s;
    logic                c_d;
    logic [PC_W-1:0]     pc_inc_s;
    logic [PC_W-1:0]     pc_tgt_s;
    logic [PC_W-1:0]     pc_d;

    assign op_s = ir_q[IW-1 -: 4];
    assign a_s  = ir_q[2*RA-1 -: RA];
    assign b_s  = ir_q[RA-1:0];

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign retire    = retire_q;
    assign halted    = halted_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;
    assign dbg_data  = regs_q[dbg_addr];

    // Decode the latched instruction into the ALU result, flag updates and the next PC.
    always_comb begin
        ra_s     = regs_q[a_s];
        rb_s     = regs_q[b_s];
        sum_s    = {1'b0, ra_s} + {1'b0, rb_s};
        // The MSB of the widened difference is the borrow, i.e. Ra < Rb unsigned.
        diff_s   = {1'b0, ra_s} - {1'b0, rb_s};
        pc_inc_s = pc_q + PC_W'(1);
        // The jump target {a,b} is truncated or zero-extended to the PC width.
        pc_tgt_s = PC_W'({a_s, b_s});
        res_d    = '0;
        wr_en_s  = 1'b0;
        upd_z_s  = 1'b0;
        upd_c_s  = 1'b0;
        c_d      = 1'b0;
        pc_d     = pc_inc_s;
        case (op_s)
            OP_ADD: begin
                res_d   = sum_s[DATA_W-1:0];
                c_d     = sum_s[DATA_W];
                wr_en_s = 1'b1;
                upd_z_s = 1'b1;
                upd_c_s = 1'b1;
            end
            OP_SUB: begin
                res_d   = diff_s[DATA_W-1:0];
                c_d     = diff_s[DATA_W];
                wr_en_s = 1'b1;
                upd_z_s = 1'b1;
                upd_c_s = 1'b1;
            end
            OP_AND: begin
                res_d   = ra_s & rb_s;
                wr_en_s = 1'b1;
                upd_z_s = 1'b1;
                upd_c_s = 1'b1;
            end
            OP_OR: begin
                res_d   = ra_s | rb_s;
                wr_en_s = 1'b1;
                upd_z_s = 1'b1;
                upd_c_s = 1'b1;
            end
            OP_XOR: begin
                res_d   = ra_s ^ rb_s;
                wr_en_s = 1'b1;
                upd_z_s = 1'b1;
                upd_c_s = 1'b1;
            end
            OP_NOT: begin
                res_d   = ~rb_s;
                wr_en_s = 1'b1;
                upd_z_s = 1'b1;
                upd_c_s = 1'b1;
            end
            OP_MOV: begin
                res_d   = rb_s;
                wr_en_s = 1'b1;
            end
            OP_MOVI: begin
                res_d   = DATA_W'(b_s);
                wr_en_s = 1'b1;
            end
            OP_CMP: begin
                res_d   = diff_s[DATA_W-1:0];
                c_d     = diff_s[DATA_W];
                upd_z_s = 1'b1;
                upd_c_s = 1'b1;
            end
            OP_JMP: begin
                pc_d = pc_tgt_s;
            end
            OP_JZ: begin
                if (z_q) begin
                    pc_d = pc_tgt_s;
                end else begin
                    pc_d = pc_inc_s;
                end
            end
            OP_JNZ: begin
                if (!z_q) begin
                    pc_d = pc_tgt_s;
                end else begin
                    pc_d = pc_inc_s;
                end
            end
            OP_HALT: begin
                pc_d = pc_q;
            end
            default: begin
                pc_d = pc_inc_s;
            end
        endcase
    end

    // Control FSM with registered handshake, retire and halted outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            imem_req_q <= 1'b0;
            retire_q   <= 1'b0;
            halted_q   <= 1'b0;
            ir_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q    <= ST_FETCH;
                    imem_req_q <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_valid) begin
                        ir_q       <= imem_data;
                        state_q    <= ST_EXEC;
                        imem_req_q <= 1'b0;
                        retire_q   <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    retire_q <= 1'b0;
                    if (op_s == OP_HALT) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q    <= ST_FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    imem_req_q <= 1'b0;
                    retire_q   <= 1'b0;
                end
            endcase
        end
    end

    // Architectural state (PC, register file, flags) commits on the edge that ends EXEC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
            z_q  <= 1'b0;
            c_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == ST_EXEC) begin
            pc_q <= pc_d;
            if (wr_en_s) begin
                regs_q[a_s] <= res_d;
            end
            if (upd_z_s) begin
                z_q <= (res_d == '0);
            end
            if (upd_c_s) begin
                c_q <= c_d;
            end
        end
    end

endmodule

// File: tb/tb_cpu_core_mc.sv
// Scoreboard bench for cpu_core_mc: each program step pushes its expected post-state.
// A monitor pops one entry per retire pulse and compares it.
module tb_cpu_core_mc;

    localparam int IW = 10;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           imem_req;
    logic [3:0]     imem_addr;
    logic           imem_valid = 1'b0;
    logic [IW-1:0]  imem_data = '0;
    logic [3:0]     pc;
    logic           retire;
    logic           halted;
    logic           flag_z;
    logic           flag_c;
    logic [2:0]     dbg_addr = 3'd0;
    logic [7:0]     dbg_data;

    cpu_core_mc dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .pc         (pc),
        .retire     (retire),
        .halted     (halted),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [3:0] pc_at;
        logic [3:0] pc_nx;
        logic       z;
        logic       c;
        logic       h;
        logic [2:0] rg;
        logic [7:0] val;
        int         gap;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          cur;
    int            checks = 0;
    int            failures = 0;
    logic [IW-1:0] rom [16];
    int            wait_tab [16];
    int            cyc = 0;
    int            last_ret = 0;
    bit            pend = 1'b0;
    bit            found;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] at, input logic [3:0] op, input logic [2:0] a,
                        input logic [2:0] b, input logic [3:0] nx, input logic z, input logic c,
                        input logic h, input logic [2:0] rg, input logic [7:0] val, input int gap);
        exp_t e;
        rom[at] = {op, a, b};
        e.pc_at = at; e.pc_nx = nx; e.z = z; e.c = c; e.h = h;
        e.rg = rg; e.val = val; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) begin
            rom[i] = {4'hC, 3'd0, 3'd0};
            wait_tab[i] = 0;
        end
    endtask

    task automatic wait_drain(input int budget, input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pend) && n < budget) begin
            @(negedge clk); #2;
            n++;
        end
        chk({nm, "_drained"}, {31'd0, (exp_q.size() == 0 && !pend)}, 32'd1);
    endtask

    // Instruction memory: answers after wait_tab[addr] request cycles, junk when idle.
    initial begin
        int fcyc;
        fcyc = 0;
        forever begin
            @(negedge clk);
            if (imem_req === 1'b1) begin
                if (fcyc >= wait_tab[imem_addr]) begin
                    imem_valid = 1'b1;
                    imem_data  = rom[imem_addr];
                end else begin
                    imem_valid = 1'b0;
                    imem_data  = {4'hC, 3'd7, 3'd7};
                end
                fcyc++;
            end else begin
                fcyc       = 0;
                imem_valid = 1'b1;
                imem_data  = {4'hC, 3'd7, 3'd7};
            end
        end
    end

    // Monitor: pop an expectation on each retire, check post-state one cycle later.
    initial begin
        forever begin
            @(negedge clk); #1;
            cyc++;
            if (pend) begin
                chk("post_pc", {28'd0, pc}, {28'd0, cur.pc_nx});
                chk("post_z", {31'd0, flag_z}, {31'd0, cur.z});
                chk("post_c", {31'd0, flag_c}, {31'd0, cur.c});
                chk("post_halted", {31'd0, halted}, {31'd0, cur.h});
                chk("post_reg", {24'd0, dbg_data}, {24'd0, cur.val});
                pend = 1'b0;
            end
            if (retire === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_retire: retire at pc %0h with no expected entry", pc);
                end else begin
                    cur = exp_q.pop_front();
                    chk("retire_pc", {28'd0, pc}, {28'd0, cur.pc_at});
                    if (cur.gap != 0) chk("retire_gap", cyc - last_ret, cur.gap);
                    dbg_addr = cur.rg;
                    pend = 1'b1;
                end
                last_ret = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Phase 1: reset values, ADD/OR program, HALT hold.
        reset = 1'b0;
        clear_mem();
        step(4'h0, 4'h7, 3'd1, 3'd3, 4'h1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h03, 0);
        step(4'h1, 4'h7, 3'd2, 3'd2, 4'h2, 1'b0, 1'b0, 1'b0, 3'd2, 8'h02, 2);
        step(4'h2, 4'h0, 3'd1, 3'd2, 4'h3, 1'b0, 1'b0, 1'b0, 3'd1, 8'h05, 2);
        step(4'h3, 4'h3, 3'd2, 3'd1, 4'h4, 1'b0, 1'b0, 1'b0, 3'd2, 8'h07, 2);
        step(4'h4, 4'hC, 3'd0, 3'd0, 4'h4, 1'b0, 1'b0, 1'b1, 3'd1, 8'h05, 2);
        repeat (3) @(negedge clk);
        chk("rst_pc", {28'd0, pc}, 32'd0);
        chk("rst_z", {31'd0, flag_z}, 32'd0);
        chk("rst_c", {31'd0, flag_c}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        reset = 1'b1;
        #1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk); #2;
        chk("fetch0_req", {31'd0, imem_req}, 32'd1);
        chk("fetch0_addr", {28'd0, imem_addr}, 32'd0);
        wait_drain(100, "p1");
        repeat (20) begin
            @(negedge clk); #2;
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            chk("halt_pc", {28'd0, pc}, 32'd4);
            chk("halt_flag", {31'd0, halted}, 32'd1);
            chk("halt_noretire", {31'd0, retire}, 32'd0);
        end

        // Phase 2: carry, NOT, CMP, branches taken/not taken, target truncation, logic ops.
        reset = 1'b0;
        clear_mem();
        step(4'h0, 4'h7, 3'd1, 3'd0, 4'h1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00, 0);
        step(4'h1, 4'h5, 3'd1, 3'd1, 4'h2, 1'b0, 1'b0, 1'b0, 3'd1, 8'hFF, 2);
        step(4'h2, 4'h7, 3'd2, 3'd1, 4'h3, 1'b0, 1'b0, 1'b0, 3'd2, 8'h01, 2);
        step(4'h3, 4'h0, 3'd1, 3'd2, 4'h4, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00, 2);
        step(4'h4, 4'h8, 3'd3, 3'd3, 4'h5, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 2);
        step(4'h5, 4'hA, 3'd1, 3'd0, 4'h8, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 2);
        step(4'h8, 4'h7, 3'd1, 3'd2, 4'h9, 1'b1, 1'b0, 1'b0, 3'd1, 8'h02, 2);
        step(4'h9, 4'h7, 3'd2, 3'd3, 4'hA, 1'b1, 1'b0, 1'b0, 3'd2, 8'h03, 2);
        step(4'hA, 4'h8, 3'd1, 3'd2, 4'hB, 1'b0, 1'b1, 1'b0, 3'd1, 8'h02, 2);
        step(4'hB, 4'hB, 3'd6, 3'd6, 4'h6, 1'b0, 1'b1, 1'b0, 3'd1, 8'h02, 2);
        step(4'h6, 4'hA, 3'd0, 3'd0, 4'h7, 1'b0, 1'b1, 1'b0, 3'd1, 8'h02, 2);
        step(4'h7, 4'h9, 3'd1, 3'd4, 4'hC, 1'b0, 1'b1, 1'b0, 3'd2, 8'h03, 2);
        step(4'hC, 4'h1, 3'd1, 3'd2, 4'hD, 1'b0, 1'b1, 1'b0, 3'd1, 8'hFF, 2);
        step(4'hD, 4'h2, 3'd2, 3'd1, 4'hE, 1'b0, 1'b0, 1'b0, 3'd2, 8'h03, 2);
        step(4'hE, 4'h4, 3'd1, 3'd1, 4'hF, 1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 2);
        step(4'hF, 4'hC, 3'd0, 3'd0, 4'hF, 1'b1, 1'b0, 1'b1, 3'd1, 8'h00, 2);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_drain(200, "p2");

        // Phase 3: PC wrap, JNZ not taken, wait states, reset during EXEC.
        reset = 1'b0;
        clear_mem();
        wait_tab[1] = 3;
        step(4'h0, 4'hB, 3'd1, 3'd6, 4'hE, 1'b0, 1'b0, 1'b0, 3'd5, 8'h00, 0);
        step(4'hE, 4'h7, 3'd5, 3'd5, 4'hF, 1'b0, 1'b0, 1'b0, 3'd5, 8'h05, 2);
        step(4'hF, 4'h4, 3'd6, 3'd6, 4'h0, 1'b1, 1'b0, 1'b0, 3'd6, 8'h00, 2);
        step(4'h0, 4'hB, 3'd1, 3'd6, 4'h1, 1'b1, 1'b0, 1'b0, 3'd5, 8'h05, 2);
        step(4'h1, 4'h7, 3'd1, 3'd6, 4'h2, 1'b1, 1'b0, 1'b0, 3'd1, 8'h06, 5);
        rom[2] = {4'h0, 3'd3, 3'd5};
        repeat (2) @(negedge clk);
        reset = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk); #2;
            if (imem_req === 1'b1 && imem_addr == 4'h1) found = 1'b1;
        end
        chk("ws_seen", {31'd0, found}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk); #2;
            end
            chk("ws_req", {31'd0, imem_req}, 32'd1);
            chk("ws_addr", {28'd0, imem_addr}, 32'd1);
            chk("ws_noretire", {31'd0, retire}, 32'd0);
        end
        @(negedge clk); #2;
        chk("ws_retire", {31'd0, retire}, 32'd1);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(posedge clk); #1;
            if (retire === 1'b1 && pc == 4'h2) found = 1'b1;
        end
        chk("abort_seen", {31'd0, found}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_pc", {28'd0, pc}, 32'd0);
        chk("abort_z", {31'd0, flag_z}, 32'd0);
        chk("abort_c", {31'd0, flag_c}, 32'd0);
        chk("abort_req", {31'd0, imem_req}, 32'd0);
        chk("abort_retire", {31'd0, retire}, 32'd0);
        chk("abort_halted", {31'd0, halted}, 32'd0);
        dbg_addr = 3'd1;
        #1;
        chk("abort_r1", {24'd0, dbg_data}, 32'd0);
        dbg_addr = 3'd3;
        #1;
        chk("abort_r3", {24'd0, dbg_data}, 32'd0);

        // Phase 4: restart after the aborted ADD; the target register must still be 0.
        clear_mem();
        step(4'h0, 4'hC, 3'd0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1, 3'd3, 8'h00, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_drain(50, "p4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
